// File: rtl/tour_reader.sv
// Streams a 64-city tour snapshot as 65 ready/valid beats (closing on city 0).
// Optional closed-tour Manhattan length accumulator built when TOUR_READER_LEN_EN is defined.
module tour_reader (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [31:0] path [64],
   input  logic [31:0] xs   [64],
   input  logic [31:0] ys   [64],
   output logic        out_valid,
   input  logic        out_ready,
   output logic [6:0]  out_idx,
   output logic [31:0] out_x,
   output logic [31:0] out_y,
   output logic        out_last,
   output logic        busy,
   output logic        done,
   output logic        err,
   output logic [31:0] tour_len
);

   // state  | meaning
   // IDLE   | waiting for start
   // SNAP   | inputs captured, beat 0 being fetched
   // STREAM | beat on out_* waiting for handshake
   // FIN    | done pulse, results held
   typedef enum logic [1:0] {IDLE, SNAP, STREAM, FIN} state_t;

   state_t      state;
   logic [31:0] snap_path [64];
   logic [31:0] snap_x    [64];
   logic [31:0] snap_y    [64];

   logic        accept;
   logic        hs;
   logic [6:0]  nxt_idx;
   logic [5:0]  sel;
   logic [31:0] city;
   logic        bad;
   logic [31:0] nxt_x;
   logic [31:0] nxt_y;

   assign accept  = (state == IDLE) && start;
   assign hs      = (state == STREAM) && out_ready;
   assign nxt_idx = (state == SNAP) ? 7'd0 : out_idx + 7'd1;
   assign sel     = nxt_idx[6] ? 6'd0 : nxt_idx[5:0];
   assign city    = snap_path[sel];
   assign bad     = |city[31:6];
   assign nxt_x   = bad ? 32'd0 : snap_x[city[5:0]];
   assign nxt_y   = bad ? 32'd0 : snap_y[city[5:0]];

   // Snapshot storage carries no reset; it is only read after an accepted start.
   always_ff @(posedge clk) begin
      if (rst && accept) begin
         snap_path <= path;
         snap_x    <= xs;
         snap_y    <= ys;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         out_valid <= 1'b0;
         out_idx   <= '0;
         out_x     <= '0;
         out_y     <= '0;
         out_last  <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         err       <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  state <= SNAP;
                  busy  <= 1'b1;
                  err   <= 1'b0;
               end
            end
            SNAP, STREAM: begin
               if (state == SNAP || out_ready) begin
                  if (state == STREAM && out_last) begin
                     state     <= FIN;
                     out_valid <= 1'b0;
                     out_last  <= 1'b0;
                     busy      <= 1'b0;
                     done      <= 1'b1;
                  end else begin
                     state     <= STREAM;
                     out_valid <= 1'b1;
                     out_idx   <= nxt_idx;
                     out_x     <= nxt_x;
                     out_y     <= nxt_y;
                     out_last  <= nxt_idx[6];
                     if (bad) err <= 1'b1;
                  end
               end
            end
            FIN: begin
               done  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef TOUR_READER_LEN_EN
   logic [31:0] prev_x;
   logic [31:0] prev_y;
   logic [31:0] dx;
   logic [31:0] dy;
   logic [33:0] sum;

   assign dx  = (out_x >= prev_x) ? out_x - prev_x : prev_x - out_x;
   assign dy  = (out_y >= prev_y) ? out_y - prev_y : prev_y - out_y;
   assign sum = {2'b00, tour_len} + {2'b00, dx} + {2'b00, dy};

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         tour_len <= '0;
         prev_x   <= '0;
         prev_y   <= '0;
      end else if (accept) begin
         tour_len <= '0;
      end else if (hs) begin
         prev_x <= out_x;
         prev_y <= out_y;
         if (out_idx != 7'd0)
            tour_len <= (|sum[33:32]) ? 32'hFFFF_FFFF : sum[31:0];
      end
   end
`else
   assign tour_len = '0;
`endif

endmodule

// File: tb/tb_tour_reader.sv
// Self-checking bench for tour_reader: tour-level model checked on every valid beat and at done.
module tb_tour_reader;
   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        start = 1'b0;
   logic [31:0] path [64];
   logic [31:0] xs   [64];
   logic [31:0] ys   [64];
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [6:0]  out_idx;
   logic [31:0] out_x, out_y;
   logic        out_last, busy, done, err;
   logic [31:0] tour_len;

   int checks = 0;
   int errors = 0;

   logic [31:0] m_path [64];
   logic [31:0] m_x    [64];
   logic [31:0] m_y    [64];
   bit          active = 0;
   bit          stall_mode = 0;
   int          beat = 0;
   int          done_cnt = 0;

   tour_reader dut (
      .clk(clk), .rst(rst), .start(start), .path(path), .xs(xs), .ys(ys),
      .out_valid(out_valid), .out_ready(out_ready), .out_idx(out_idx),
      .out_x(out_x), .out_y(out_y), .out_last(out_last), .busy(busy),
      .done(done), .err(err), .tour_len(tour_len)
   );

   always #5 clk = ~clk;

   always @(posedge clk) #1 out_ready = stall_mode ? ~out_ready : 1'b1;

   function automatic logic [31:0] ex_x(int k);
      logic [31:0] c = m_path[k == 64 ? 0 : k];
      return (c >= 64) ? 32'd0 : m_x[c[5:0]];
   endfunction

   function automatic logic [31:0] ex_y(int k);
      logic [31:0] c = m_path[k == 64 ? 0 : k];
      return (c >= 64) ? 32'd0 : m_y[c[5:0]];
   endfunction

   function automatic logic [63:0] absd(logic [31:0] a, logic [31:0] b);
      return (a >= b) ? 64'(a - b) : 64'(b - a);
   endfunction

   function automatic logic [31:0] model_len();
      logic [63:0] acc = 0;
      for (int k = 1; k <= 64; k++) begin
         acc += absd(ex_x(k), ex_x(k-1)) + absd(ex_y(k), ex_y(k-1));
         if (acc > 64'hFFFF_FFFF) acc = 64'hFFFF_FFFF;
      end
      return acc[31:0];
   endfunction

   function automatic logic model_err();
      for (int k = 0; k < 64; k++) if (m_path[k] >= 64) return 1'b1;
      return 1'b0;
   endfunction

   function automatic logic [31:0] exp_len();
`ifdef TOUR_READER_LEN_EN
      return model_len();
`else
      return 32'd0;
`endif
   endfunction

   task automatic check(string name, logic [63:0] act, logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   // Compare process: beats against the model, results at done.
   always @(negedge clk) begin
      if (rst) begin
         if (done) begin
            check("done_expected", {63'd0, active}, 64'd1);
            check("beats_at_done", 64'(beat), 64'd65);
            check("err_at_done", {63'd0, err}, {63'd0, model_err()});
            check("len_at_done", 64'(tour_len), 64'(exp_len()));
            active = 0;
            done_cnt++;
         end else if (active && out_valid) begin
            check("beat_idx", 64'(out_idx), 64'(beat));
            check("beat_xy", {out_x, out_y}, {ex_x(beat), ex_y(beat)});
            check("beat_last", {63'd0, out_last}, {63'd0, beat == 64});
            check("busy_stream", {63'd0, busy}, 64'd1);
            if (out_ready) beat++;
         end
      end
   end

   task automatic start_tour();
      m_path = path; m_x = xs; m_y = ys;
      @(posedge clk) #1 start = 1'b1;
      beat = 0;
      active = 1;
      @(posedge clk) #1 start = 1'b0;
      @(negedge clk);
      check("snap_valid_low", {62'd0, out_valid, busy}, 64'd1);
      @(negedge clk);
      check("first_valid_lat2", {63'd0, out_valid}, 64'd1);
   endtask

   task automatic wait_done();
      int n0 = done_cnt;
      int t = 0;
      while (done_cnt == n0 && t < 600) begin
         @(negedge clk);
         t++;
      end
      if (done_cnt == n0) check("done_timeout", 64'd0, 64'd1);
      @(posedge clk) #1;
   endtask

   task automatic wait_beat(int b);
      int t = 0;
      while (beat < b && t < 600) begin
         @(negedge clk);
         t++;
      end
      if (beat < b) check("beat_timeout", 64'(beat), 64'(b));
   endtask

   task automatic base_inputs();
      for (int i = 0; i < 64; i++) begin
         path[i] = 32'(i); xs[i] = 32'(i); ys[i] = 32'd0;
      end
   endtask

   initial begin
      base_inputs();
      #1;
      check("reset_outputs", {out_valid, busy, done, err, out_last, out_idx, out_x, out_y, tour_len},
            '0);
      #20 rst = 1'b1;
      repeat (2) @(posedge clk);

      // Basic tour: consecutive beats, beat 64 closes on city 0.
      start_tour();
      wait_done();
`ifdef TOUR_READER_LEN_EN
      check("len_basic_126", 64'(tour_len), 64'd126);
`else
      check("len_tied_zero", 64'(tour_len), 64'd0);
`endif
      check("idle_after", {62'd0, busy, out_valid}, 64'd0);

      // Alternating stall.
      stall_mode = 1;
      start_tour();
      wait_done();
      stall_mode = 0;
`ifdef TOUR_READER_LEN_EN
      check("len_stall_126", 64'(tour_len), 64'd126);
`endif

      // Out-of-range city at beat 5.
      path[5] = 32'd70;
      start_tour();
      wait_done();
      check("err_literal", {63'd0, err}, 64'd1);
`ifdef TOUR_READER_LEN_EN
      check("len_bad_134", 64'(tour_len), 64'd134);
`endif
      repeat (3) @(posedge clk);
      check("err_held", {63'd0, err}, 64'd1);
      base_inputs();

      // Saturation of the length accumulator.
      for (int i = 0; i < 64; i++) xs[i] = i[0] ? 32'hFFFF_FFFF : 32'd0;
      start_tour();
      wait_done();
`ifdef TOUR_READER_LEN_EN
      check("len_saturate", 64'(tour_len), 64'hFFFF_FFFF);
`endif
      base_inputs();

      // Start and new inputs mid-stream must not disturb the snapshot.
      start_tour();
      wait_beat(10);
      @(posedge clk) #1 start = 1'b1;
      for (int i = 0; i < 64; i++) begin
         path[i] = 32'(63 - i); xs[i] = 32'(1000 + i); ys[i] = 32'(7 * i);
      end
      @(posedge clk) #1 start = 1'b0;
      wait_done();
      repeat (4) @(posedge clk);
      #1 check("no_restart", {62'd0, busy, out_valid}, 64'd0);
      base_inputs();

      // Async reset mid-stream, then a full tour.
      start_tour();
      wait_beat(30);
      @(negedge clk) #2 rst = 1'b0;
      active = 0;
      #1 check("async_reset_zero",
               {out_valid, busy, done, err, out_last, out_idx, out_x, out_y, tour_len}, '0);
      repeat (3) @(posedge clk);
      #1 check("no_done_in_reset", {63'd0, done}, 64'd0);
      @(negedge clk) rst = 1'b1;
      repeat (2) @(posedge clk);
      check("no_done_after_abort", 64'(done_cnt), 64'd5);
      start_tour();
      wait_done();
      check("tours_completed", 64'(done_cnt), 64'd6);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
